// File: rtl/sad_window_accum.sv
// Windowed sum-of-absolute-differences accumulator: one {sad, disp} result and a
// registered update pulse per candidate disparity, framed by startsig/done.
module sad_window_accum #(
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned WIN_LEN  = 1024,
    parameter int unsigned NUM_DISP = 64,
    parameter int unsigned SAD_W    = 18,
    parameter int unsigned CNT_W    = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_pix_valid,
    output logic             o_pix_ready,
    input  logic [PIX_W-1:0] i_pix_l,
    input  logic [PIX_W-1:0] i_pix_r,
    output logic             o_startsig,
    output logic             o_update,
    output logic [SAD_W-1:0] o_sad,
    output logic [7:0]       o_disp,
    output logic             o_done
);
    typedef enum logic [2:0] {StIdle, StAccum, StEmit, StPulse, StDone} state_e;

    localparam int unsigned      SumW     = SAD_W + 1;
    localparam logic [CNT_W-1:0] LastCnt  = CNT_W'(WIN_LEN - 1);
    localparam logic [7:0]       LastDisp = 8'(NUM_DISP - 1);

    state_e           r_state;
    logic [SAD_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_d;
    logic [SAD_W-1:0] r_sad;
    logic [7:0]       r_disp;
    logic             r_pix_ready;
    logic             r_startsig;
    logic             r_update;
    logic             r_done;

    logic [PIX_W-1:0] w_diff;
    logic [SumW-1:0]  w_sum;
    logic [SAD_W-1:0] w_acc_next;
    logic             w_beat;

    assign w_diff = (i_pix_l >= i_pix_r) ? (i_pix_l - i_pix_r) : (i_pix_r - i_pix_l);
    assign w_sum  = {1'b0, r_acc} + SumW'(w_diff);
    // The carry bit flags overflow; clamp to all-ones instead of wrapping.
    assign w_acc_next = w_sum[SAD_W] ? {SAD_W{1'b1}} : w_sum[SAD_W-1:0];
    assign w_beat     = i_pix_valid & r_pix_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_d         <= '0;
            r_sad       <= '0;
            r_disp      <= '0;
            r_pix_ready <= 1'b0;
            r_startsig  <= 1'b0;
            r_update    <= 1'b0;
            r_done      <= 1'b0;
        end else if (i_start) begin
            // Abort from any state; a beat presented alongside start is dropped.
            r_state     <= StAccum;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_d         <= '0;
            r_pix_ready <= 1'b1;
            r_startsig  <= 1'b1;
            r_update    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_startsig <= 1'b0;
            case (r_state)
                StIdle: begin
                end
                StAccum: begin
                    if (w_beat) begin
                        if (r_cnt == LastCnt) begin
                            r_sad       <= w_acc_next;
                            r_disp      <= r_d;
                            r_pix_ready <= 1'b0;
                            r_state     <= StEmit;
                        end else begin
                            r_acc <= w_acc_next;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                StEmit: begin
                    // sad/disp settled last edge, so update rises on clean data.
                    r_update <= 1'b1;
                    r_state  <= StPulse;
                end
                StPulse: begin
                    r_update <= 1'b0;
                    if (r_d == LastDisp) begin
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_d         <= r_d + 8'd1;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_pix_ready <= 1'b1;
                        r_state     <= StAccum;
                    end
                end
                StDone: begin
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_pix_ready = r_pix_ready;
    assign o_startsig  = r_startsig;
    assign o_update    = r_update;
    assign o_sad       = r_sad;
    assign o_disp      = r_disp;
    assign o_done      = r_done;

endmodule

// File: tb/tb_sad_window_accum.sv
// Bench for sad_window_accum: a small instance (WIN_LEN=4, NUM_DISP=3) for the
// protocol scenarios and a default-parameter instance for the full-range run.
module tb_sad_window_accum;
    localparam int WIN     = 4;
    localparam int ND      = 3;
    localparam int SAD_MAX = (1 << 18) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_s = 1'b0, valid_s = 1'b0;
    logic [7:0] l_s = '0, r_s = '0;
    logic       ready_s, startsig_s, update_s, done_s;
    logic [17:0] sad_s;
    logic [7:0]  disp_s;

    logic       start_b = 1'b0, valid_b = 1'b0;
    logic [7:0] l_b = '0, r_b = '0;
    logic       ready_b, startsig_b, update_b, done_b;
    logic [17:0] sad_b;
    logic [7:0]  disp_b;

    sad_window_accum #(
        .PIX_W(8), .WIN_LEN(WIN), .NUM_DISP(ND), .SAD_W(18), .CNT_W(2)
    ) u_dut_s (
        .i_clk(clk), .i_rst(rst), .i_start(start_s), .i_pix_valid(valid_s),
        .o_pix_ready(ready_s), .i_pix_l(l_s), .i_pix_r(r_s), .o_startsig(startsig_s),
        .o_update(update_s), .o_sad(sad_s), .o_disp(disp_s), .o_done(done_s)
    );

    sad_window_accum u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_pix_valid(valid_b),
        .o_pix_ready(ready_b), .i_pix_l(l_b), .i_pix_r(r_b), .o_startsig(startsig_b),
        .o_update(update_b), .o_sad(sad_b), .o_disp(disp_b), .o_done(done_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observer on the small instance: records every update and pulse shape.
    int          cyc = 0;
    logic        upd_prev = 1'b0;
    logic [17:0] sad_prev = '0;
    int          upd_run = 0;
    int          q_sad[$];
    int          q_disp[$];
    int          n_unstable = 0, n_wide = 0, n_startsig = 0;
    int          startsig_cyc = 0, first_gap = -1;

    always @(negedge clk) begin
        cyc++;
        if (startsig_s) begin
            n_startsig++;
            startsig_cyc = cyc;
            first_gap = -1;
        end
        if (update_s && !upd_prev) begin
            q_sad.push_back(int'(sad_s));
            q_disp.push_back(int'(disp_s));
            if (sad_s !== sad_prev) n_unstable++;
            if (first_gap < 0) first_gap = cyc - startsig_cyc;
        end
        if (update_s) upd_run++;
        else begin
            if (upd_run > 1) n_wide++;
            upd_run = 0;
        end
        upd_prev = update_s;
        sad_prev = sad_s;
    end

    int exp_sad[$];
    int exp_disp[$];

    task automatic clear_mon();
        q_sad.delete();
        q_disp.delete();
        exp_sad.delete();
        exp_disp.delete();
        n_unstable = 0;
        n_wide = 0;
        n_startsig = 0;
        first_gap = -1;
    endtask

    task automatic gen_pair(input int mode, input int d, output logic [7:0] l,
                            output logic [7:0] r);
        case (mode)
            0: begin l = 8'($urandom); r = l; end
            1: begin
                case (d)
                    0: begin l = 8'd200; r = 8'd50; end
                    1: begin l = 8'd10; r = 8'd250; end
                    default: begin l = 8'd7; r = 8'd7; end
                endcase
            end
            default: begin l = 8'($urandom); r = 8'($urandom); end
        endcase
    endtask

    // One full search on the small instance; the model sums |L-R| per window.
    task automatic drive_search(input int mode, input bit gaps, output int beats,
                                output bit timed_out);
        int acc;
        logic [7:0] l, r;
        clear_mon();
        @(negedge clk); start_s = 1'b1; valid_s = 1'b0;
        @(negedge clk); start_s = 1'b0;
        beats = 0;
        acc = 0;
        timed_out = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (c > 0) @(negedge clk);
            if (done_s) begin
                timed_out = 1'b0;
                break;
            end
            gen_pair(mode, beats / WIN, l, r);
            valid_s = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            l_s = l;
            r_s = r;
            if (valid_s && ready_s) begin
                acc += (l > r) ? int'(l) - int'(r) : int'(r) - int'(l);
                beats++;
                if (beats % WIN == 0) begin
                    exp_sad.push_back(acc > SAD_MAX ? SAD_MAX : acc);
                    exp_disp.push_back(beats / WIN - 1);
                    acc = 0;
                end
            end
        end
        valid_s = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic feed_s(input int n, input logic [7:0] l, input logic [7:0] r);
        int got = 0;
        for (int c = 0; c < 50 && got < n; c++) begin
            @(negedge clk);
            valid_s = 1'b1;
            l_s = l;
            r_s = r;
            if (ready_s) got++;
        end
        @(negedge clk);
        valid_s = 1'b0;
    endtask

    task automatic check_results(input string tag);
        n_checks++;
        if (q_sad.size() !== exp_sad.size()) begin
            n_fail++;
            $display("FAIL %s result_count: got %0d expected %0d", tag, q_sad.size(),
                     exp_sad.size());
        end
        for (int i = 0; i < q_sad.size() && i < exp_sad.size(); i++) begin
            n_checks += 2;
            if (q_sad[i] !== exp_sad[i]) begin
                n_fail++;
                $display("FAIL %s sad[%0d]: got %0d expected %0d", tag, i, q_sad[i], exp_sad[i]);
            end
            if (q_disp[i] !== exp_disp[i]) begin
                n_fail++;
                $display("FAIL %s disp[%0d]: got %0d expected %0d", tag, i, q_disp[i],
                         exp_disp[i]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks += 6;
        if (ready_s !== 1'b0) begin n_fail++; $display("FAIL reset ready: got %b expected 0", ready_s); end
        if (startsig_s !== 1'b0) begin n_fail++; $display("FAIL reset startsig: got %b expected 0", startsig_s); end
        if (update_s !== 1'b0) begin n_fail++; $display("FAIL reset update: got %b expected 0", update_s); end
        if (sad_s !== 18'd0) begin n_fail++; $display("FAIL reset sad: got %0d expected 0", sad_s); end
        if (disp_s !== 8'd0) begin n_fail++; $display("FAIL reset disp: got %0d expected 0", disp_s); end
        if (done_s !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done_s); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_equal_pixels();
        int beats;
        bit to;
        drive_search(0, 1'b0, beats, to);
        n_checks += 2;
        if (to !== 1'b0) begin n_fail++; $display("FAIL equal done_reached: got timeout expected done"); end
        if (n_wide !== 0) begin n_fail++; $display("FAIL equal update_width: got %0d wide pulses expected 0", n_wide); end
        check_results("equal");
        for (int i = 0; i < q_sad.size(); i++) begin
            n_checks++;
            if (q_sad[i] !== 0) begin n_fail++; $display("FAIL equal sad_zero[%0d]: got %0d expected 0", i, q_sad[i]); end
        end
    endtask

    task automatic test_fixed_pairs();
        int beats;
        bit to;
        int lit[3] = '{600, 960, 0};
        drive_search(1, 1'b0, beats, to);
        check_results("fixed");
        for (int i = 0; i < q_sad.size() && i < 3; i++) begin
            n_checks++;
            if (q_sad[i] !== lit[i]) begin
                n_fail++;
                $display("FAIL fixed sad_literal[%0d]: got %0d expected %0d", i, q_sad[i], lit[i]);
            end
        end
    endtask

    task automatic test_random_gaps();
        int beats;
        bit to;
        drive_search(2, 1'b1, beats, to);
        n_checks += 6;
        if (to !== 1'b0) begin n_fail++; $display("FAIL gaps done_reached: got timeout expected done"); end
        if (beats !== WIN * ND) begin n_fail++; $display("FAIL gaps beat_count: got %0d expected %0d", beats, WIN * ND); end
        if (n_wide !== 0) begin n_fail++; $display("FAIL gaps update_width: got %0d wide pulses expected 0", n_wide); end
        if (n_unstable !== 0) begin n_fail++; $display("FAIL gaps sad_stable: got %0d changes expected 0", n_unstable); end
        if (n_startsig !== 1) begin n_fail++; $display("FAIL gaps startsig_count: got %0d expected 1", n_startsig); end
        if (first_gap < WIN + 1) begin n_fail++; $display("FAIL gaps startsig_lead: got %0d expected >= %0d", first_gap, WIN + 1); end
        check_results("gaps");
    endtask

    task automatic test_abort();
        clear_mon();
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        feed_s(WIN, 8'd5, 8'd5);
        feed_s(2, 8'd100, 8'd0);
        @(negedge clk); start_s = 1'b1; valid_s = 1'b1; l_s = 8'd255; r_s = 8'd0;
        @(negedge clk); start_s = 1'b0; valid_s = 1'b0;
        n_checks++;
        if (startsig_s !== 1'b1) begin n_fail++; $display("FAIL abort startsig: got %b expected 1", startsig_s); end
        feed_s(WIN, 8'd3, 8'd1);
        for (int c = 0; c < 20 && q_sad.size() < 2; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_checks += 2;
        if (q_sad.size() !== 2) begin n_fail++; $display("FAIL abort update_count: got %0d expected 2", q_sad.size()); end
        if (n_startsig !== 2) begin n_fail++; $display("FAIL abort startsig_count: got %0d expected 2", n_startsig); end
        if (q_sad.size() >= 2) begin
            n_checks += 3;
            if (q_sad[0] !== 0) begin n_fail++; $display("FAIL abort first_sad: got %0d expected 0", q_sad[0]); end
            if (q_disp[1] !== 0) begin n_fail++; $display("FAIL abort restart_disp: got %0d expected 0", q_disp[1]); end
            if (q_sad[1] !== 8) begin n_fail++; $display("FAIL abort restart_sad: got %0d expected 8", q_sad[1]); end
        end
    endtask

    task automatic test_rst_in_pulse();
        int beats;
        bit to;
        bit hit = 1'b0;
        clear_mon();
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clk);
            if (update_s && disp_s == 8'(ND - 1)) begin
                hit = 1'b1;
                rst = 1'b1;
                valid_s = 1'b0;
                break;
            end
            valid_s = 1'b1;
            l_s = 8'($urandom_range(128, 255));
            r_s = 8'($urandom_range(0, 127));
        end
        @(negedge clk);
        n_checks += 6;
        if (hit !== 1'b1) begin n_fail++; $display("FAIL rst_pulse reached_pulse: got %b expected 1", hit); end
        if (update_s !== 1'b0) begin n_fail++; $display("FAIL rst_pulse update: got %b expected 0", update_s); end
        if (sad_s !== 18'd0) begin n_fail++; $display("FAIL rst_pulse sad: got %0d expected 0", sad_s); end
        if (disp_s !== 8'd0) begin n_fail++; $display("FAIL rst_pulse disp: got %0d expected 0", disp_s); end
        if (done_s !== 1'b0) begin n_fail++; $display("FAIL rst_pulse done: got %b expected 0", done_s); end
        if (ready_s !== 1'b0) begin n_fail++; $display("FAIL rst_pulse ready: got %b expected 0", ready_s); end
        rst = 1'b0;
        drive_search(2, 1'b0, beats, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL rst_pulse resume_done: got timeout expected done"); end
        check_results("rst_resume");
    endtask

    task automatic test_defaults_full_range();
        int  n_upd = 0;
        logic prev = 1'b0;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0; valid_b = 1'b1; l_b = 8'd255; r_b = 8'd0;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clk);
            if (update_b && !prev) begin
                n_checks += 2;
                if (sad_b !== 18'd261120) begin
                    n_fail++;
                    $display("FAIL defaults sad[%0d]: got %0d expected 261120", n_upd, sad_b);
                end
                if (int'(disp_b) !== n_upd) begin
                    n_fail++;
                    $display("FAIL defaults disp[%0d]: got %0d expected %0d", n_upd, disp_b, n_upd);
                end
                n_upd++;
            end
            prev = update_b;
            if (done_b) break;
        end
        valid_b = 1'b0;
        n_checks += 2;
        if (n_upd !== 64) begin n_fail++; $display("FAIL defaults update_count: got %0d expected 64", n_upd); end
        if (done_b !== 1'b1) begin n_fail++; $display("FAIL defaults done: got %b expected 1", done_b); end
    endtask

    initial begin
        test_reset();
        test_equal_pixels();
        test_fixed_pairs();
        test_random_gaps();
        test_abort();
        test_rst_in_pulse();
        test_defaults_full_range();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
